// File: rtl/conv2d3x3_window_ctrl_pkg.sv
// rtl/conv2d3x3_window_ctrl_pkg.sv - shared state encoding and frame counter width for the 3x3 window controller
package conv2d3x3_window_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } ctrl_state_e;

  localparam int FRAME_CNT_WIDTH = 16;

endpackage

// File: rtl/conv2d3x3_window_ctrl_if.sv
// rtl/conv2d3x3_window_ctrl_if.sv - pixel/window handshake bundle between source, controller and MAC stage
interface conv2d3x3_window_ctrl_if #(
  parameter int DATA_WIDTH = 14
);
  logic                  Start;
  logic                  In_Valid;
  logic                  In_Ready;
  logic                  LB_Wr_En;
  logic                  Win_Valid;
  logic                  Out_Ready;
  logic [DATA_WIDTH-1:0] Row_Idx;
  logic [DATA_WIDTH-1:0] Col_Idx;
  logic                  Busy;
  logic                  Done;

  modport slave (
    input  Start, In_Valid, Out_Ready,
    output In_Ready, LB_Wr_En, Win_Valid, Row_Idx, Col_Idx, Busy, Done
  );

  modport master (
    output Start, In_Valid, Out_Ready,
    input  In_Ready, LB_Wr_En, Win_Valid, Row_Idx, Col_Idx, Busy, Done
  );
endinterface

// File: rtl/conv2d3x3_raster_counter.sv
// rtl/conv2d3x3_raster_counter.sv - raster-scan row/column counter with last-pixel flag
module conv2d3x3_raster_counter #(
  parameter int DATA_WIDTH = 14,
  parameter int IMG_SIZE   = 100
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  clr,
  input  logic                  en,
  output logic [DATA_WIDTH-1:0] row,
  output logic [DATA_WIDTH-1:0] col,
  output logic                  last
);
  localparam logic [DATA_WIDTH-1:0] EDGE = DATA_WIDTH'(IMG_SIZE - 1);

  assign last = (row == EDGE) && (col == EDGE);

  // Row returns to 0 after the final pixel so the pair never leaves the image
  always_ff @(posedge Clk) begin
    if (Rst || clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col == EDGE) begin
        col <= '0;
        row <= last ? '0 : row + DATA_WIDTH'(1);
      end else begin
        col <= col + DATA_WIDTH'(1);
      end
    end
  end
endmodule

// File: rtl/conv2d3x3_window_ctrl.sv
// rtl/conv2d3x3_window_ctrl.sv - 3x3 window sequencing controller; CONV2D_WINDOW_CTRL_FRAME_CNT_EN adds Frame_Cnt
module conv2d3x3_window_ctrl
  import conv2d3x3_window_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 14,
  parameter int IMG_SIZE   = 100
) (
  input  logic                          Clk,
  input  logic                          Rst,
  conv2d3x3_window_ctrl_if.slave        ctl
`ifdef CONV2D_WINDOW_CTRL_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_WIDTH-1:0]    Frame_Cnt
`endif
);
  ctrl_state_e           state;
  logic                  win_valid;
  logic                  done;
  logic [DATA_WIDTH-1:0] row_idx;
  logic [DATA_WIDTH-1:0] col_idx;
  logic [DATA_WIDTH-1:0] row;
  logic [DATA_WIDTH-1:0] col;
  logic                  last_pix;
  logic                  in_ready;
  logic                  accept;
  logic                  win_load;

  assign in_ready = (state == RUN) && (!win_valid || ctl.Out_Ready);
  assign accept   = ctl.In_Valid && in_ready;
  assign win_load = accept && (row >= DATA_WIDTH'(2)) && (col >= DATA_WIDTH'(2));

  conv2d3x3_raster_counter #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMG_SIZE   (IMG_SIZE)
  ) u_raster (
    .Clk  (Clk),
    .Rst  (Rst),
    .clr  (state == IDLE),
    .en   (accept),
    .row  (row),
    .col  (col),
    .last (last_pix)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      win_valid <= 1'b0;
      done      <= 1'b0;
      row_idx   <= '0;
      col_idx   <= '0;
    end else begin
      done <= 1'b0;
      // A load in the handoff cycle wins so the window register never bubbles
      if (win_load) begin
        win_valid <= 1'b1;
        row_idx   <= row - DATA_WIDTH'(1);
        col_idx   <= col - DATA_WIDTH'(1);
      end else if (ctl.Out_Ready) begin
        win_valid <= 1'b0;
      end
      case (state)
        IDLE:    if (ctl.Start && !done) state <= RUN;
        RUN:     if (accept && last_pix) state <= FLUSH;
        FLUSH: begin
          if (win_valid && ctl.Out_Ready) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ctl.In_Ready  = in_ready;
  assign ctl.LB_Wr_En  = accept;
  assign ctl.Win_Valid = win_valid;
  assign ctl.Row_Idx   = row_idx;
  assign ctl.Col_Idx   = col_idx;
  assign ctl.Busy      = (state != IDLE);
  assign ctl.Done      = done;

`ifdef CONV2D_WINDOW_CTRL_FRAME_CNT_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Frame_Cnt <= '0;
    end else if (done) begin
      Frame_Cnt <= Frame_Cnt + FRAME_CNT_WIDTH'(1);
    end
  end
`endif
endmodule

// File: tb/tb_conv2d3x3_window_ctrl.sv
// tb/tb_conv2d3x3_window_ctrl.sv - scoreboard bench for conv2d3x3_window_ctrl; CONV2D_WINDOW_CTRL_FRAME_CNT_EN checks Frame_Cnt
module tb_conv2d3x3_window_ctrl;
  import conv2d3x3_window_ctrl_pkg::*;

  localparam int DW   = 14;
  localparam int IMG  = 5;
  localparam int NPIX = IMG * IMG;
  localparam int NWIN = (IMG - 2) * (IMG - 2);

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  conv2d3x3_window_ctrl_if #(.DATA_WIDTH(DW)) ctl ();
`ifdef CONV2D_WINDOW_CTRL_FRAME_CNT_EN
  logic [FRAME_CNT_WIDTH-1:0] Frame_Cnt;
`endif

  conv2d3x3_window_ctrl #(
    .DATA_WIDTH (DW),
    .IMG_SIZE   (IMG)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .ctl (ctl)
`ifdef CONV2D_WINDOW_CTRL_FRAME_CNT_EN
    ,
    .Frame_Cnt (Frame_Cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct { int r; int c; } win_t;
  win_t exp_q[$];
  win_t w;
  bit   mon_en  = 1'b0;
  bit   mon_run = 1'b0;
  bit   pend    = 1'b0;
  int   cyc = 0;
  int   pix_cnt, win_cnt, done_cnt, first_acc, last_acc, last_hand;
  int   pr, pc;
  int   exp_frames = 0;

  // Monitor: expected windows are derived from the bench's own pixel count
  always @(negedge Clk) begin
    cyc++;
    if (mon_en) begin
      if (pend) begin
        check("win_valid_after_load", ctl.Win_Valid, 1);
        if (exp_q.size() > 0) begin
          check("load_row", ctl.Row_Idx, exp_q[$].r);
          check("load_col", ctl.Col_Idx, exp_q[$].c);
        end
        pend = 1'b0;
      end
      check("in_ready", ctl.In_Ready, mon_run && (!ctl.Win_Valid || ctl.Out_Ready));
      check("lb_wr_en", ctl.LB_Wr_En, ctl.In_Valid && mon_run && (!ctl.Win_Valid || ctl.Out_Ready));
      if (ctl.Win_Valid && ctl.Out_Ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_window", 1, 0);
        end else begin
          w = exp_q.pop_front();
          check("handoff_row", ctl.Row_Idx, w.r);
          check("handoff_col", ctl.Col_Idx, w.c);
        end
        win_cnt++;
        last_hand = cyc;
      end
      if (ctl.LB_Wr_En) begin
        pr = pix_cnt / IMG;
        pc = pix_cnt % IMG;
        if (pix_cnt == 0) first_acc = cyc;
        last_acc = cyc;
        if (pr >= 2 && pc >= 2) begin
          exp_q.push_back('{pr - 1, pc - 1});
          pend = 1'b1;
        end
        pix_cnt++;
        if (pix_cnt == NPIX) mon_run = 1'b0;
      end
      if (ctl.Done) begin
        done_cnt++;
        check("done_after_last_handoff", cyc, last_hand + 1);
        check("busy_in_done", ctl.Busy, 0);
        check("windows_before_done", win_cnt, NWIN);
      end
    end
  end

  task automatic begin_frame();
    exp_q.delete();
    pix_cnt = 0; win_cnt = 0; done_cnt = 0; pend = 1'b0;
    first_acc = 0; last_acc = 0; last_hand = -10;
    mon_run = 1'b0;
    mon_en  = 1'b1;
    ctl.Start = 1'b1; ctl.In_Valid = 1'b0; ctl.Out_Ready = 1'b1;
    @(posedge Clk); #1;
    ctl.Start = 1'b0;
    mon_run   = 1'b1;
    check("busy_after_start", ctl.Busy, 1);
  endtask

  task automatic run_frame(input int valid_pct, input bit stall_first, input bit start_noise);
    bit stalled = 1'b0;
    int t = 0;
    begin_frame();
    while (done_cnt == 0 && t < 2000) begin
      ctl.In_Valid = ($urandom_range(99) < valid_pct);
      ctl.Start    = start_noise ? 1'($urandom_range(1)) : 1'b0;
      if (stall_first && !stalled && ctl.Win_Valid) begin
        stalled = 1'b1;
        ctl.Out_Ready = 1'b0;
        repeat (3) begin
          @(negedge Clk);
          check("stall_win_valid", ctl.Win_Valid, 1);
          check("stall_in_ready", ctl.In_Ready, 0);
          check("stall_row", ctl.Row_Idx, 1);
          check("stall_col", ctl.Col_Idx, 1);
          @(posedge Clk); #1;
        end
        ctl.Out_Ready = 1'b1;
      end
      @(posedge Clk); #1;
      t++;
    end
    ctl.Start = 1'b0; ctl.In_Valid = 1'b0;
    check("frame_timeout", t < 2000, 1);
    check("done_count", done_cnt, 1);
    check("window_count", win_cnt, NWIN);
    check("accept_count", pix_cnt, NPIX);
    if (valid_pct == 100 && !stall_first) check("no_bubbles", last_acc - first_acc, NPIX - 1);
    @(negedge Clk);
    check("busy_after_done", ctl.Busy, 0);
    check("done_single_cycle", ctl.Done, 0);
    exp_frames++;
`ifdef CONV2D_WINDOW_CTRL_FRAME_CNT_EN
    check("frame_cnt", Frame_Cnt, exp_frames);
`endif
    mon_en = 1'b0;
    @(posedge Clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bit done_any;
    int t;
    ctl.Start = 1'b0; ctl.In_Valid = 1'b1; ctl.Out_Ready = 1'b0;
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    repeat (10) begin
      @(negedge Clk);
      check("idle_outputs", {ctl.In_Ready, ctl.LB_Wr_En, ctl.Win_Valid, ctl.Busy,
                             ctl.Done, ctl.Row_Idx, ctl.Col_Idx}, 0);
    end
`ifdef CONV2D_WINDOW_CTRL_FRAME_CNT_EN
    check("frame_cnt_reset", Frame_Cnt, 0);
`endif
    @(posedge Clk); #1;

    run_frame(100, 1'b0, 1'b0);
    run_frame(100, 1'b1, 1'b0);
    run_frame(50,  1'b0, 1'b1);

    // Mid-frame reset after 12 accepted pixels
    begin_frame();
    ctl.In_Valid = 1'b1;
    t = 0;
    while (pix_cnt < 12 && t < 200) begin
      @(posedge Clk); #1;
      t++;
    end
    check("midreset_reach_pixel", pix_cnt, 12);
    mon_en = 1'b0; mon_run = 1'b0;
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(negedge Clk);
    check("midreset_outputs", {ctl.In_Ready, ctl.LB_Wr_En, ctl.Win_Valid, ctl.Busy,
                               ctl.Done, ctl.Row_Idx, ctl.Col_Idx}, 0);
    exp_frames = 0;
`ifdef CONV2D_WINDOW_CTRL_FRAME_CNT_EN
    check("midreset_frame_cnt", Frame_Cnt, 0);
`endif
    done_any = 1'b0;
    repeat (10) begin
      @(negedge Clk);
      done_any = done_any | ctl.Done;
    end
    check("midreset_no_done", done_any, 0);
    ctl.In_Valid = 1'b0;
    @(posedge Clk); #1;

    for (int f = 0; f < 3; f++) run_frame(100, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/conv2d3x3_window_ctrl.md
# conv2d3x3_window_ctrl

Sequencing controller for the 3x3 convolution datapath. It accepts a raster-scan pixel stream over a valid/ready handshake and tracks the row and column of each accepted pixel. It drives the line-buffer shift enable and flags each cycle in which the 3x3 window held by the line buffers is complete, with registered backpressure toward the MAC stage. It sits between the pixel source and the line-buffer/MAC datapath and frames one image per Start pulse.

## Interface
- DATA_WIDTH, 14, width of row/column counters
- IMG_SIZE, 100, square image edge in pixels; legal range 3 ≤ IMG_SIZE < 2^DATA_WIDTH
- Clk  input  1  clock; all logic on rising edge
- Rst  input  1  reset, synchronous, active-high
- Start  input  1  begin a frame; sampled only in IDLE
- In_Valid  input  1  source pixel present
- In_Ready  output  1  controller accepts pixel this cycle
- LB_Wr_En  output  1  line-buffer shift/write enable, = In_Valid & In_Ready
- Win_Valid  output  1  registered; window ready for MAC
- Out_Ready  input  1  MAC stage takes window
- Row_Idx  output  DATA_WIDTH  row of the window centre pixel, 1..IMG_SIZE-2
- Col_Idx  output  DATA_WIDTH  column of the window centre pixel, 1..IMG_SIZE-2
- Busy  output  1  high outside IDLE
- Done  output  1  one-cycle pulse at end of frame

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE: In_Ready=0. Start=1 → RUN. Counters r=c=0.
- RUN:
  - In_Ready = !Win_Valid | Out_Ready.
  - Each accept (LB_Wr_En=1) advances c. At c=IMG_SIZE-1, c→0 and r→r+1.
  - An accept at r≥2 and c≥2 sets Win_Valid next cycle. Row_Idx=r-1 and Col_Idx=c-1 are captured at the same time.
  - An accept of pixel (IMG_SIZE-1, IMG_SIZE-1) → FLUSH.
- FLUSH: In_Ready=0. Wait until Win_Valid & Out_Ready, then Done=1 for one cycle and → IDLE.
- Win_Valid clears on Out_Ready unless a new window is loaded in the same cycle. Simultaneous handoff and load keeps Win_Valid=1 with the new indices.
- Windows per frame: (IMG_SIZE-2)^2. Pixels with r<2 or c<2 only prime the line buffers.
- Start is ignored outside IDLE. In_Valid is ignored when In_Ready=0.
- Counter arithmetic is unsigned, DATA_WIDTH bits; indices never wrap within a frame.

## Timing
- Reset values: In_Ready=0, LB_Wr_En=0, Win_Valid=0, Row_Idx=0, Col_Idx=0, Busy=0, Done=0. State is IDLE.
- Start to first In_Ready: 1 cycle (Start at cycle t, RUN at t+1).
- Accept to Win_Valid: 1 cycle.
- With Out_Ready held at 1: one pixel per cycle, no bubbles.
- Last window handoff to Done: 1 cycle. Busy is low in the Done cycle.
- Rst mid-frame: everything returns to reset values on the next edge. The partial frame is discarded and no Done is issued.
- Start in the same cycle as Done: ignored. A new frame needs Start with Busy=0 and Done=0.

## Configuration
- Macro: CONV2D_WINDOW_CTRL_FRAME_CNT_EN.
- Defined: adds output Frame_Cnt, 16 bits, reset 0. It increments on every Done pulse and wraps at 2^16.
- Undefined: no Frame_Cnt port and no counter logic. All other behaviour is identical.

## Structure
- Shared package: state encoding (IDLE=2'd0, RUN=2'd1, FLUSH=2'd2) and the FRAME_CNT_WIDTH=16 constant, for reuse by the conv2d top and the testbench.
- Sub-module: conv2d3x3_raster_counter, holding the row/column pair with enable, wrap, and last-pixel flag. The FSM and the window/handshake register stay in the top.

## Test plan
- Reset and idle, IMG_SIZE=5:
  - Hold Rst 2 cycles, then Start=0 for 10 cycles → all outputs 0, In_Ready=0.
- Full frame, no backpressure, IMG_SIZE=5:
  - Start, In_Valid=1, Out_Ready=1 → 25 accepts in 25 consecutive cycles.
  - 9 Win_Valid cycles; first window carries Row_Idx=1, Col_Idx=1, one cycle after accepting pixel (2,2).
  - Done one cycle after the last window; Busy then 0.
- Backpressure, IMG_SIZE=5:
  - Out_Ready=0 for 3 cycles when the first window appears → Win_Valid held, In_Ready=0, indices stable.
  - After release, remaining windows are (1,2), (1,3), (2,1) … (3,3).
- Source gaps, IMG_SIZE=5:
  - Random In_Valid ~50% → same 9 windows in order, no extra LB_Wr_En pulses.
- Mid-frame reset, IMG_SIZE=5:
  - Rst at pixel 12 → next cycle all reset values, no Done.
  - A new Start yields a clean 9-window frame.
- Frame counter, macro defined:
  - Three back-to-back frames → Frame_Cnt reads 1, 2, 3 after each Done.
  - Start during Busy has no effect.
